pipe_hazard_ctrl: RTL and testbench

//  Hazard/stall controller for the 5-stage RV32 pipeline. Consumes the ID/EX register outputs and the ID-stage

---
 rtl/pipe_hazard_ctrl_if.sv | 36 +++
 rtl/pipe_hazard_ctrl.sv | 123 ++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// Interface between the RV32 pipeline datapath and its hazard/stall controller.
// The pipeline side is the master; the controller is the slave.
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       id_raa;
    logic [4:0]       id_rba;
    logic             id_uses_ra;
    logic             id_uses_rb;
    logic [4:0]       ex_rd;
    logic             ex_memread;
    logic             ex_alumul;
    logic             ex_jump_taken;
    logic             pc_stall;
    logic             ifid_stall;
    logic             ifid_flush;
    logic             idie_stall;
    logic             idie_flush;
    logic             mul_busy;
    logic             mul_last;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output id_raa, id_rba, id_uses_ra, id_uses_rb,
        output ex_rd, ex_memread, ex_alumul, ex_jump_taken,
        input  pc_stall, ifid_stall, ifid_flush, idie_stall, idie_flush,
        input  mul_busy, mul_last, stall_cnt
    );

    modport slave (
        input  id_raa, id_rba, id_uses_ra, id_uses_rb,
        input  ex_rd, ex_memread, ex_alumul, ex_jump_taken,
        output pc_stall, ifid_stall, ifid_flush, idie_stall, idie_flush,
        output mul_busy, mul_last, stall_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/stall controller for the 5-stage RV32 pipeline: taken-jump flush,
// load-use bubble, multi-cycle EX multiply hold, saturating stall-cycle counter.
module pipe_hazard_ctrl #(
    parameter int MUL_CYCLES = 4,
    parameter int CNT_W      = 16
) (
    input logic               clk,
    input logic               rst,
    pipe_hazard_ctrl_if.slave hz
);

    typedef enum logic [1:0] {
        RUN = 2'd0,
        MUL = 2'd1
    } state_t;

    localparam bit         MUL_HOLD   = (MUL_CYCLES > 1);
    localparam logic [3:0] MUL_RELOAD = (MUL_CYCLES > 1) ? 4'(MUL_CYCLES - 2) : 4'd0;

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic pc_stall, ifid_stall, ifid_flush, idie_stall, idie_flush;
    logic mul_busy, mul_last;

    // Per-source RAW match against the load in EX; x0 never creates a hazard.
    logic [1:0] src_uses;
    logic [4:0] src_addr [2];
    logic [1:0] src_hit;
    logic       load_use;

    assign src_uses    = {hz.id_uses_rb, hz.id_uses_ra};
    assign src_addr[0] = hz.id_raa;
    assign src_addr[1] = hz.id_rba;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_src
            assign src_hit[gi] = src_uses[gi] && (src_addr[gi] == hz.ex_rd);
        end
    endgenerate

    assign load_use = hz.ex_memread && (hz.ex_rd != 5'd0) && (|src_hit);

    always_comb begin
        pc_stall   = 1'b0;
        ifid_stall = 1'b0;
        ifid_flush = 1'b0;
        idie_stall = 1'b0;
        idie_flush = 1'b0;
        mul_busy   = 1'b0;
        mul_last   = 1'b0;
        state_d    = state_q;
        cnt_d      = cnt_q;

        case (state_q)
            RUN: begin
                if (hz.ex_jump_taken) begin
                    ifid_flush = 1'b1;
                    idie_flush = 1'b1;
                end else if (hz.ex_alumul) begin
                    if (MUL_HOLD) begin
                        pc_stall   = 1'b1;
                        ifid_stall = 1'b1;
                        idie_stall = 1'b1;
                        cnt_d      = MUL_RELOAD;
                        state_d    = MUL;
                    end else begin
                        mul_last = 1'b1;
                    end
                end else if (load_use) begin
                    pc_stall   = 1'b1;
                    ifid_stall = 1'b1;
                    idie_flush = 1'b1;
                end
            end
            MUL: begin
                // Jumps and load-use are masked: the multiply owns EX until done.
                mul_busy = 1'b1;
                if (cnt_q != 4'd0) begin
                    pc_stall   = 1'b1;
                    ifid_stall = 1'b1;
                    idie_stall = 1'b1;
                    cnt_d      = cnt_q - 4'd1;
                end else begin
                    mul_last = 1'b1;
                    state_d  = RUN;
                end
            end
            default: begin
                state_d = RUN;
                cnt_d   = 4'd0;
            end
        endcase

        stall_cnt_d = stall_cnt_q;
        if (pc_stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= RUN;
            cnt_q       <= 4'd0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign hz.pc_stall   = pc_stall;
    assign hz.ifid_stall = ifid_stall;
    assign hz.ifid_flush = ifid_flush;
    assign hz.idie_stall = idie_stall;
    assign hz.idie_flush = idie_flush;
    assign hz.mul_busy   = mul_busy;
    assign hz.mul_last   = mul_last;
    assign hz.stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: main instance (MUL_CYCLES=4, CNT_W=16)
// plus a CNT_W=4 instance for counter saturation.
module tb_pipe_hazard_ctrl;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    pipe_hazard_ctrl_if #(.CNT_W(16)) hz ();
    pipe_hazard_ctrl_if #(.CNT_W(4))  hz4 ();

    pipe_hazard_ctrl #(.MUL_CYCLES(4), .CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz)
    );

    pipe_hazard_ctrl #(.MUL_CYCLES(4), .CNT_W(4)) dut_sat (
        .clk (clk),
        .rst (rst),
        .hz  (hz4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        hz.id_raa = 5'd0;  hz.id_rba = 5'd0;  hz.id_uses_ra = 1'b0;  hz.id_uses_rb = 1'b0;
        hz.ex_rd = 5'd0;   hz.ex_memread = 1'b0;  hz.ex_alumul = 1'b0;  hz.ex_jump_taken = 1'b0;
        hz4.id_raa = 5'd0; hz4.id_rba = 5'd0; hz4.id_uses_ra = 1'b0; hz4.id_uses_rb = 1'b0;
        hz4.ex_rd = 5'd0;  hz4.ex_memread = 1'b0; hz4.ex_alumul = 1'b0; hz4.ex_jump_taken = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle();
        tick();
        tick();
        checks++; if (hz.pc_stall !== 1'b0) begin failures++; $display("FAIL rst_pc_stall got=%b want=0", hz.pc_stall); end
        checks++; if (hz.mul_busy !== 1'b0) begin failures++; $display("FAIL rst_mul_busy got=%b want=0", hz.mul_busy); end
        checks++; if (hz.stall_cnt !== 16'd0) begin failures++; $display("FAIL rst_stall_cnt got=%0d want=0", hz.stall_cnt); end
        checks++; if (hz4.stall_cnt !== 4'd0) begin failures++; $display("FAIL rst_sat_stall_cnt got=%0d want=0", hz4.stall_cnt); end
        rst = 1'b1;
        tick();
        checks++; if ({hz.ifid_flush, hz.idie_flush, hz.idie_stall, hz.mul_last} !== 4'b0) begin failures++; $display("FAIL rst_ctrl got=%b want=0000", {hz.ifid_flush, hz.idie_flush, hz.idie_stall, hz.mul_last}); end
        $display("txn reset: stall_cnt=%0d", hz.stall_cnt);
    endtask

    task automatic test_load_use();
        hz.ex_memread = 1'b1; hz.ex_rd = 5'd5; hz.id_raa = 5'd5; hz.id_uses_ra = 1'b1;
        #1;
        checks++; if (hz.pc_stall !== 1'b1) begin failures++; $display("FAIL lu_pc_stall got=%b want=1", hz.pc_stall); end
        checks++; if (hz.ifid_stall !== 1'b1) begin failures++; $display("FAIL lu_ifid_stall got=%b want=1", hz.ifid_stall); end
        checks++; if (hz.idie_flush !== 1'b1) begin failures++; $display("FAIL lu_idie_flush got=%b want=1", hz.idie_flush); end
        checks++; if ({hz.idie_stall, hz.ifid_flush} !== 2'b00) begin failures++; $display("FAIL lu_other got=%b want=00", {hz.idie_stall, hz.ifid_flush}); end
        tick();
        idle();
        #1;
        checks++; if (hz.pc_stall !== 1'b0) begin failures++; $display("FAIL lu_bubble_pc_stall got=%b want=0", hz.pc_stall); end
        checks++; if (hz.stall_cnt !== 16'd1) begin failures++; $display("FAIL lu_stall_cnt got=%0d want=1", hz.stall_cnt); end
        $display("txn load_use: stall_cnt=%0d", hz.stall_cnt);
    endtask

    task automatic test_no_stall();
        hz.ex_memread = 1'b1; hz.ex_rd = 5'd0; hz.id_raa = 5'd0; hz.id_uses_ra = 1'b1;
        #1;
        checks++; if (hz.pc_stall !== 1'b0) begin failures++; $display("FAIL x0_pc_stall got=%b want=0", hz.pc_stall); end
        hz.ex_rd = 5'd7; hz.id_raa = 5'd3; hz.id_rba = 5'd7; hz.id_uses_rb = 1'b0;
        #1;
        checks++; if (hz.pc_stall !== 1'b0) begin failures++; $display("FAIL unused_rb_pc_stall got=%b want=0", hz.pc_stall); end
        hz.id_uses_rb = 1'b1;
        #1;
        checks++; if (hz.pc_stall !== 1'b1) begin failures++; $display("FAIL rb_hit_pc_stall got=%b want=1", hz.pc_stall); end
        idle();
        tick();
        checks++; if (hz.stall_cnt !== 16'd1) begin failures++; $display("FAIL no_stall_cnt got=%0d want=1", hz.stall_cnt); end
        $display("txn no_stall: stall_cnt=%0d", hz.stall_cnt);
    endtask

    task automatic test_mul();
        hz.ex_alumul = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            if (c == 2) begin
                hz.ex_jump_taken = 1'b1;
                hz.ex_memread = 1'b1; hz.ex_rd = 5'd9; hz.id_raa = 5'd9; hz.id_uses_ra = 1'b1;
            end
            #1;
            checks++; if (hz.pc_stall !== (c < 4)) begin failures++; $display("FAIL mul_pc_stall c=%0d got=%b want=%b", c, hz.pc_stall, (c < 4)); end
            checks++; if (hz.idie_stall !== (c < 4)) begin failures++; $display("FAIL mul_idie_stall c=%0d got=%b want=%b", c, hz.idie_stall, (c < 4)); end
            checks++; if (hz.mul_busy !== (c > 1)) begin failures++; $display("FAIL mul_busy c=%0d got=%b want=%b", c, hz.mul_busy, (c > 1)); end
            checks++; if (hz.mul_last !== (c == 4)) begin failures++; $display("FAIL mul_last c=%0d got=%b want=%b", c, hz.mul_last, (c == 4)); end
            if (c == 2) begin
                checks++; if ({hz.ifid_flush, hz.idie_flush} !== 2'b00) begin failures++; $display("FAIL mul_masks_jump got=%b want=00", {hz.ifid_flush, hz.idie_flush}); end
                hz.ex_jump_taken = 1'b0;
                hz.ex_memread = 1'b0;
            end
            if (c == 4) hz.ex_alumul = 1'b0;
            tick();
            $display("txn mul cycle %0d: stall_cnt=%0d", c, hz.stall_cnt);
        end
        idle();
        #1;
        checks++; if (hz.mul_busy !== 1'b0) begin failures++; $display("FAIL mul_done_busy got=%b want=0", hz.mul_busy); end
        checks++; if (hz.stall_cnt !== 16'd4) begin failures++; $display("FAIL mul_stall_cnt got=%0d want=4", hz.stall_cnt); end
    endtask

    task automatic test_jump_load_use();
        hz.ex_jump_taken = 1'b1;
        hz.ex_memread = 1'b1; hz.ex_rd = 5'd12; hz.id_rba = 5'd12; hz.id_uses_rb = 1'b1;
        #1;
        checks++; if ({hz.ifid_flush, hz.idie_flush} !== 2'b11) begin failures++; $display("FAIL jmp_flush got=%b want=11", {hz.ifid_flush, hz.idie_flush}); end
        checks++; if ({hz.pc_stall, hz.ifid_stall, hz.idie_stall} !== 3'b000) begin failures++; $display("FAIL jmp_stalls got=%b want=000", {hz.pc_stall, hz.ifid_stall, hz.idie_stall}); end
        tick();
        idle();
        #1;
        checks++; if (hz.stall_cnt !== 16'd4) begin failures++; $display("FAIL jmp_stall_cnt got=%0d want=4", hz.stall_cnt); end
        $display("txn jump_load_use: stall_cnt=%0d", hz.stall_cnt);
    endtask

    task automatic test_back_to_back();
        int lasts;
        lasts = 0;
        hz.ex_alumul = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            #1;
            if (hz.mul_last === 1'b1) lasts++;
            checks++; if (hz.pc_stall !== ((c % 4) != 0)) begin failures++; $display("FAIL b2b_pc_stall c=%0d got=%b want=%b", c, hz.pc_stall, ((c % 4) != 0)); end
            checks++; if (hz.mul_last !== ((c % 4) == 0)) begin failures++; $display("FAIL b2b_mul_last c=%0d got=%b want=%b", c, hz.mul_last, ((c % 4) == 0)); end
            checks++; if (hz.mul_busy !== ((c % 4) != 1)) begin failures++; $display("FAIL b2b_mul_busy c=%0d got=%b want=%b", c, hz.mul_busy, ((c % 4) != 1)); end
            if (c == 8) hz.ex_alumul = 1'b0;
            tick();
            $display("txn b2b cycle %0d: stall_cnt=%0d", c, hz.stall_cnt);
        end
        #1;
        checks++; if (lasts != 2) begin failures++; $display("FAIL b2b_last_pulses got=%0d want=2", lasts); end
        checks++; if (hz.stall_cnt !== 16'd10) begin failures++; $display("FAIL b2b_stall_cnt got=%0d want=10", hz.stall_cnt); end
        checks++; if (hz.mul_busy !== 1'b0) begin failures++; $display("FAIL b2b_done_busy got=%b want=0", hz.mul_busy); end
    endtask

    task automatic test_reset_mid_mul();
        hz.ex_alumul = 1'b1;
        tick();
        #1;
        checks++; if (hz.mul_busy !== 1'b1) begin failures++; $display("FAIL rmm_busy_before got=%b want=1", hz.mul_busy); end
        rst = 1'b0;
        hz.ex_alumul = 1'b0;
        #1;
        checks++; if (hz.mul_busy !== 1'b0) begin failures++; $display("FAIL rmm_busy got=%b want=0", hz.mul_busy); end
        checks++; if (hz.stall_cnt !== 16'd0) begin failures++; $display("FAIL rmm_stall_cnt got=%0d want=0", hz.stall_cnt); end
        tick();
        rst = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            checks++; if ({hz.mul_last, hz.mul_busy} !== 2'b00) begin failures++; $display("FAIL rmm_no_last c=%0d got=%b want=00", c, {hz.mul_last, hz.mul_busy}); end
            tick();
        end
        $display("txn reset_mid_mul: stall_cnt=%0d", hz.stall_cnt);
    endtask

    task automatic test_saturation();
        hz4.ex_memread = 1'b1; hz4.ex_rd = 5'd4; hz4.id_raa = 5'd4; hz4.id_uses_ra = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (c == 14) begin
                checks++; if (hz4.stall_cnt !== 4'd14) begin failures++; $display("FAIL sat_14 got=%0d want=14", hz4.stall_cnt); end
            end
            if (c == 15) begin
                checks++; if (hz4.stall_cnt !== 4'd15) begin failures++; $display("FAIL sat_15 got=%0d want=15", hz4.stall_cnt); end
            end
        end
        checks++; if (hz4.stall_cnt !== 4'd15) begin failures++; $display("FAIL sat_20 got=%0d want=15", hz4.stall_cnt); end
        idle();
        $display("txn saturation: stall_cnt=%0d", hz4.stall_cnt);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_load_use();
        test_no_stall();
        test_mul();
        test_jump_load_use();
        test_back_to_back();
        test_reset_mid_mul();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
